// File: rtl/shared_resource_arbiter_if.sv
// Request/issue/response bundle between the two pipelines, the shared resource and the arbiter.
// slave = arbiter side, master = pipeline/resource side.
interface shared_resource_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              req_valid_1;
   logic              req_valid_2;
   logic [DATA_W-1:0] req_data_1;
   logic [DATA_W-1:0] req_data_2;
   logic              req_flush_1;
   logic              req_flush_2;
   logic              req_stall_1;
   logic              req_stall_2;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_valid_1;
   logic              rsp_valid_2;
   logic [DATA_W-1:0] rsp_data_1;
   logic [DATA_W-1:0] rsp_data_2;

   modport slave (
      input  req_valid_1, req_valid_2, req_data_1, req_data_2,
      input  req_flush_1, req_flush_2, rsp_valid, rsp_data,
      output req_stall_1, req_stall_2, res_valid, res_data,
      output rsp_valid_1, rsp_valid_2, rsp_data_1, rsp_data_2
   );

   modport master (
      output req_valid_1, req_valid_2, req_data_1, req_data_2,
      output req_flush_1, req_flush_2, rsp_valid, rsp_data,
      input  req_stall_1, req_stall_2, res_valid, res_data,
      input  rsp_valid_1, rsp_valid_2, rsp_data_1, rsp_data_2
   );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Two-requester round-robin arbiter for one shared fixed-latency resource, with ID tracking,
// response steering, flush and global stall. Define ARB_PERF_CNT_EN to add the perf counters.
//
// last_win state | meaning
// WIN_1          | requester 1 won the last conflict, requester 2 wins the next
// WIN_2          | requester 2 won the last conflict (reset), requester 1 wins the next
module shared_resource_arbiter #(
   parameter int DATA_W  = 32,
   parameter int LATENCY = 3
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     global_stall,
   shared_resource_arbiter_if.slave bus,
   output logic                     err_tag
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [15:0]              perf_grant_1,
   output logic [15:0]              perf_grant_2,
   output logic [15:0]              perf_conflict
`endif
);

   localparam int TAIL = LATENCY - 1;

   typedef enum logic {
      WIN_1 = 1'b0,
      WIN_2 = 1'b1
   } win_e;

   win_e              last_win_q, last_win_d;
   logic              run;
   logic              eff_1, eff_2;
   logic              grant_1, grant_2;
   logic              conflict;

   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;
   logic              iss_id_q, iss_id_d;

   logic [LATENCY-1:0] trk_v_q, trk_v_d;
   logic [LATENCY-1:0] trk_id_q, trk_id_d;
   logic [LATENCY-1:0] trk_kill_q, trk_kill_d;
   logic [LATENCY-1:0] kill_now;
   logic               flush_issue;

   logic              tail_v, tail_id, tail_kill, tail_flush, deliver;
   logic              rsp_valid_1_q, rsp_valid_1_d;
   logic              rsp_valid_2_q, rsp_valid_2_d;
   logic [DATA_W-1:0] rsp_data_1_q, rsp_data_1_d;
   logic [DATA_W-1:0] rsp_data_2_q, rsp_data_2_d;
   logic              err_tag_q, err_tag_d;

   assign run   = ~global_stall;
   assign eff_1 = bus.req_valid_1 & ~bus.req_flush_1;
   assign eff_2 = bus.req_valid_2 & ~bus.req_flush_2;

   always_comb begin
      grant_1    = 1'b0;
      grant_2    = 1'b0;
      conflict   = run & eff_1 & eff_2;
      last_win_d = last_win_q;
      if (conflict) begin
         grant_1    = (last_win_q == WIN_2);
         grant_2    = (last_win_q == WIN_1);
         last_win_d = (last_win_q == WIN_2) ? WIN_1 : WIN_2;
      end else if (run) begin
         grant_1 = eff_1;
         grant_2 = eff_2;
      end
   end

   assign bus.req_stall_1 = global_stall | (bus.req_valid_1 & ~grant_1);
   assign bus.req_stall_2 = global_stall | (bus.req_valid_2 & ~grant_2);

   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      iss_id_d    = iss_id_q;
      if (run) begin
         res_valid_d = grant_1 | grant_2;
         if (grant_1) begin
            res_data_d = bus.req_data_1;
            iss_id_d   = 1'b0;
         end else if (grant_2) begin
            res_data_d = bus.req_data_2;
            iss_id_d   = 1'b1;
         end
      end
   end

   // Flush kill bits update even while stalled; only the shift waits for a run cycle.
   always_comb begin
      kill_now    = '0;
      flush_issue = res_valid_q & (iss_id_q ? bus.req_flush_2 : bus.req_flush_1);
      for (int i = 0; i < LATENCY; i++) begin
         kill_now[i] = trk_kill_q[i] | (trk_id_q[i] ? bus.req_flush_2 : bus.req_flush_1);
      end
      trk_v_d    = trk_v_q;
      trk_id_d   = trk_id_q;
      trk_kill_d = kill_now;
      if (run) begin
         trk_v_d[0]    = res_valid_q;
         trk_id_d[0]   = iss_id_q;
         trk_kill_d[0] = flush_issue;
         for (int i = 1; i < LATENCY; i++) begin
            trk_v_d[i]    = trk_v_q[i-1];
            trk_id_d[i]   = trk_id_q[i-1];
            trk_kill_d[i] = kill_now[i-1];
         end
      end
   end

   assign tail_v     = trk_v_q[TAIL];
   assign tail_id    = trk_id_q[TAIL];
   assign tail_kill  = trk_kill_q[TAIL];
   assign tail_flush = tail_id ? bus.req_flush_2 : bus.req_flush_1;
   assign deliver    = bus.rsp_valid & tail_v & ~tail_kill & ~tail_flush;

   always_comb begin
      rsp_valid_1_d = rsp_valid_1_q;
      rsp_valid_2_d = rsp_valid_2_q;
      rsp_data_1_d  = rsp_data_1_q;
      rsp_data_2_d  = rsp_data_2_q;
      err_tag_d     = err_tag_q;
      if (run) begin
         rsp_valid_1_d = deliver & ~tail_id;
         rsp_valid_2_d = deliver & tail_id;
         if (deliver & ~tail_id) rsp_data_1_d = bus.rsp_data;
         if (deliver & tail_id)  rsp_data_2_d = bus.rsp_data;
         err_tag_d = err_tag_q | (bus.rsp_valid != tail_v);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_win_q    <= WIN_2;
         res_valid_q   <= 1'b0;
         res_data_q    <= '0;
         iss_id_q      <= 1'b0;
         trk_v_q       <= '0;
         trk_id_q      <= '0;
         trk_kill_q    <= '0;
         rsp_valid_1_q <= 1'b0;
         rsp_valid_2_q <= 1'b0;
         rsp_data_1_q  <= '0;
         rsp_data_2_q  <= '0;
         err_tag_q     <= 1'b0;
      end else begin
         last_win_q    <= last_win_d;
         res_valid_q   <= res_valid_d;
         res_data_q    <= res_data_d;
         iss_id_q      <= iss_id_d;
         trk_v_q       <= trk_v_d;
         trk_id_q      <= trk_id_d;
         trk_kill_q    <= trk_kill_d;
         rsp_valid_1_q <= rsp_valid_1_d;
         rsp_valid_2_q <= rsp_valid_2_d;
         rsp_data_1_q  <= rsp_data_1_d;
         rsp_data_2_q  <= rsp_data_2_d;
         err_tag_q     <= err_tag_d;
      end
   end

   assign bus.res_valid   = res_valid_q;
   assign bus.res_data    = res_data_q;
   assign bus.rsp_valid_1 = rsp_valid_1_q;
   assign bus.rsp_valid_2 = rsp_valid_2_q;
   assign bus.rsp_data_1  = rsp_data_1_q;
   assign bus.rsp_data_2  = rsp_data_2_q;
   assign err_tag         = err_tag_q;

`ifdef ARB_PERF_CNT_EN
   logic [15:0] pg_1_q, pg_1_d;
   logic [15:0] pg_2_q, pg_2_d;
   logic [15:0] pc_q, pc_d;

   always_comb begin
      pg_1_d = pg_1_q;
      pg_2_d = pg_2_q;
      pc_d   = pc_q;
      if (grant_1 && pg_1_q != 16'hFFFF)  pg_1_d = pg_1_q + 16'd1;
      if (grant_2 && pg_2_q != 16'hFFFF)  pg_2_d = pg_2_q + 16'd1;
      if (conflict && pc_q != 16'hFFFF)   pc_d   = pc_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pg_1_q <= '0;
         pg_2_q <= '0;
         pc_q   <= '0;
      end else begin
         pg_1_q <= pg_1_d;
         pg_2_q <= pg_2_d;
         pc_q   <= pc_d;
      end
   end

   assign perf_grant_1  = pg_1_q;
   assign perf_grant_2  = pg_2_q;
   assign perf_conflict = pc_q;
`endif

endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed bench for shared_resource_arbiter with a behavioural LATENCY-deep resource that
// returns the bitwise inverse of each issued payload.
module tb_shared_resource_arbiter;

   localparam int DATA_W  = 32;
   localparam int LATENCY = 3;

   logic clk;
   logic reset;
   logic global_stall;
   logic err_tag;
`ifdef ARB_PERF_CNT_EN
   logic [15:0] perf_grant_1, perf_grant_2, perf_conflict;
`endif

   shared_resource_arbiter_if #(.DATA_W(DATA_W)) bus ();

   shared_resource_arbiter #(.DATA_W(DATA_W), .LATENCY(LATENCY)) dut (
      .clk          (clk),
      .reset        (reset),
      .global_stall (global_stall),
      .bus          (bus),
      .err_tag      (err_tag)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_grant_1 (perf_grant_1),
      .perf_grant_2 (perf_grant_2),
      .perf_conflict(perf_conflict)
`endif
   );

   int checks;
   int errors;

   logic        rsp_ovr_en;
   logic        rsp_ovr_v;
   logic [31:0] rsp_ovr_d;

   logic        mdl_v [LATENCY];
   logic [31:0] mdl_d [LATENCY];

   logic [31:0] exp_iss [4] = '{32'h0000_1000, 32'h0000_2001, 32'h0000_1002, 32'h0000_2003};
   logic [31:0] exp_rsp [4] = '{32'hFFFF_EFFF, 32'hFFFF_DFFE, 32'hFFFF_EFFD, 32'hFFFF_DFFC};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Resource model: advances only on non-stalled cycles, mid-cycle, and is not reset.
   initial begin
      for (int i = 0; i < LATENCY; i++) begin
         mdl_v[i] = 1'b0;
         mdl_d[i] = '0;
      end
      bus.rsp_valid = 1'b0;
      bus.rsp_data  = '0;
      forever begin
         @(negedge clk);
         if (!global_stall) begin
            if (rsp_ovr_en) begin
               bus.rsp_valid = rsp_ovr_v;
               bus.rsp_data  = rsp_ovr_d;
            end else begin
               bus.rsp_valid = mdl_v[LATENCY-1];
               bus.rsp_data  = mdl_d[LATENCY-1];
            end
            for (int i = LATENCY - 1; i > 0; i--) begin
               mdl_v[i] = mdl_v[i-1];
               mdl_d[i] = mdl_d[i-1];
            end
            mdl_v[0] = bus.res_valid;
            mdl_d[0] = ~bus.res_data;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rsp_ovr_en = 1'b0;
      rsp_ovr_v  = 1'b0;
      rsp_ovr_d  = '0;
      reset = 1'b1;
      global_stall = 1'b0;
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b0;
      bus.req_data_1  = '0;
      bus.req_data_2  = '0;
      bus.req_flush_1 = 1'b0;
      bus.req_flush_2 = 1'b0;
      #2 reset = 1'b0;
      tick();

      // reset state
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_rsp_valid_1", bus.rsp_valid_1, 0);
      check("rst_rsp_valid_2", bus.rsp_valid_2, 0);
      check("rst_err_tag", err_tag, 0);
      check("rst_req_stall_1", bus.req_stall_1, 0);
      tick();

      // single requester, granted in the first cycle after reset release
      reset = 1'b1;
      bus.req_valid_1 = 1'b1;
      bus.req_data_1  = 32'hA5A5_0001;
      #1;
      check("t1_req_stall_1", bus.req_stall_1, 0);
      check("t1_req_stall_2", bus.req_stall_2, 0);
      tick();
      bus.req_valid_1 = 1'b0;
      check("t1_res_valid_hi", bus.res_valid, 1);
      check("t1_res_data", bus.res_data, 32'hA5A5_0001);
      tick();
      check("t1_res_valid_lo", bus.res_valid, 0);
      tick();
      tick();
      check("t1_rsp_valid_1_early", bus.rsp_valid_1, 0);
      tick();
      check("t1_rsp_valid_1", bus.rsp_valid_1, 1);
      check("t1_rsp_data_1", bus.rsp_data_1, 32'h5A5A_FFFE);
      check("t1_rsp_valid_2", bus.rsp_valid_2, 0);
      tick();
      check("t1_rsp_valid_1_clr", bus.rsp_valid_1, 0);
      check("t1_err_tag", err_tag, 0);

      // conflict round-robin: 1,2,1,2
      for (int i = 0; i < 4; i++) begin
         bus.req_valid_1 = 1'b1;
         bus.req_valid_2 = 1'b1;
         bus.req_data_1  = 32'h0000_1000 + 32'(i);
         bus.req_data_2  = 32'h0000_2000 + 32'(i);
         #1;
         check("t2_req_stall_1", bus.req_stall_1, 32'(i % 2));
         check("t2_req_stall_2", bus.req_stall_2, 32'((i + 1) % 2));
         if (i > 0) check("t2_res_data", bus.res_data, exp_iss[i-1]);
         tick();
      end
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b0;
      check("t2_res_valid", bus.res_valid, 1);
      check("t2_res_data_last", bus.res_data, exp_iss[3]);
`ifdef ARB_PERF_CNT_EN
      check("t2_perf_conflict", perf_conflict, 4);
      check("t2_perf_grant_1", perf_grant_1, 3);
      check("t2_perf_grant_2", perf_grant_2, 2);
`endif
      for (int j = 0; j < 4; j++) begin
         tick();
         check("t2_rsp_valid_1", bus.rsp_valid_1, 32'((j + 1) % 2));
         check("t2_rsp_valid_2", bus.rsp_valid_2, 32'(j % 2));
         if (j % 2 == 0) check("t2_rsp_data_1", bus.rsp_data_1, exp_rsp[j]);
         else            check("t2_rsp_data_2", bus.rsp_data_2, exp_rsp[j]);
      end
      tick();

      // flush in flight: issue 1,2,1 then flush requester 1
      bus.req_valid_1 = 1'b1;
      bus.req_data_1  = 32'h0000_3000;
      tick();
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b1;
      bus.req_data_2  = 32'h0000_3001;
      tick();
      bus.req_valid_2 = 1'b0;
      bus.req_valid_1 = 1'b1;
      bus.req_data_1  = 32'h0000_3002;
      #1;
      check("t3_req_stall_1", bus.req_stall_1, 0);
      tick();
      bus.req_valid_1 = 1'b0;
      bus.req_flush_1 = 1'b1;
      #1;
      check("t3_res_data", bus.res_data, 32'h0000_3002);
      tick();
      bus.req_flush_1 = 1'b0;
      tick();
      check("t3_drop_a_v1", bus.rsp_valid_1, 0);
      check("t3_drop_a_v2", bus.rsp_valid_2, 0);
      tick();
      check("t3_keep_v2", bus.rsp_valid_2, 1);
      check("t3_keep_d2", bus.rsp_data_2, 32'hFFFF_CFFE);
      check("t3_keep_v1", bus.rsp_valid_1, 0);
      tick();
      check("t3_drop_b_v1", bus.rsp_valid_1, 0);
      check("t3_drop_b_v2", bus.rsp_valid_2, 0);
      check("t3_err_tag", err_tag, 0);
      tick();

      // global stall for 5 cycles with an issue pending
      bus.req_valid_2 = 1'b1;
      bus.req_data_2  = 32'h0000_4000;
      tick();
      bus.req_valid_2 = 1'b0;
      global_stall    = 1'b1;
      bus.req_valid_1 = 1'b1;
      bus.req_data_1  = 32'h0000_4444;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("t4_req_stall_1", bus.req_stall_1, 1);
         check("t4_req_stall_2", bus.req_stall_2, 1);
         check("t4_res_valid_hold", bus.res_valid, 1);
         check("t4_res_data_hold", bus.res_data, 32'h0000_4000);
         tick();
      end
      global_stall    = 1'b0;
      bus.req_valid_1 = 1'b0;
      #1;
      check("t4_res_valid_s6", bus.res_valid, 1);
      tick();
      check("t4_res_valid_s7", bus.res_valid, 0);
      tick();
      tick();
      check("t4_rsp_valid_2_early", bus.rsp_valid_2, 0);
      tick();
      check("t4_rsp_valid_2", bus.rsp_valid_2, 1);
      check("t4_rsp_data_2", bus.rsp_data_2, 32'hFFFF_BFFF);
      check("t4_rsp_valid_1", bus.rsp_valid_1, 0);
      global_stall = 1'b1;
      tick();
      check("t4_rsp_valid_2_held", bus.rsp_valid_2, 1);
      global_stall = 1'b0;
      tick();
      check("t4_rsp_valid_2_clr", bus.rsp_valid_2, 0);
      check("t4_err_tag", err_tag, 0);
      tick();

      // protocol error: response with an empty tracker
      rsp_ovr_en = 1'b1;
      rsp_ovr_v  = 1'b1;
      rsp_ovr_d  = 32'h0000_DEAD;
      tick();
      rsp_ovr_en = 1'b0;
      rsp_ovr_v  = 1'b0;
      check("t5_err_tag", err_tag, 1);
      check("t5_rsp_valid_1", bus.rsp_valid_1, 0);
      check("t5_rsp_valid_2", bus.rsp_valid_2, 0);
      tick();

      // reset with three operations in flight
      bus.req_valid_1 = 1'b1;
      bus.req_data_1  = 32'h0000_5000;
      tick();
      bus.req_valid_1 = 1'b0;
      bus.req_valid_2 = 1'b1;
      bus.req_data_2  = 32'h0000_5001;
      tick();
      bus.req_valid_2 = 1'b0;
      bus.req_valid_1 = 1'b1;
      bus.req_data_1  = 32'h0000_5002;
      tick();
      bus.req_valid_1 = 1'b0;
      check("t6_res_valid_pre", bus.res_valid, 1);
      reset = 1'b0;
      #1;
      check("t6_res_valid", bus.res_valid, 0);
      check("t6_res_data", bus.res_data, 0);
      check("t6_rsp_data_1", bus.rsp_data_1, 0);
      check("t6_rsp_data_2", bus.rsp_data_2, 0);
      check("t6_err_tag_clr", err_tag, 0);
`ifdef ARB_PERF_CNT_EN
      check("t6_perf_conflict", perf_conflict, 0);
      check("t6_perf_grant_1", perf_grant_1, 0);
`endif
      tick();
      reset = 1'b1;
      tick();
      check("t6_err_tag_set", err_tag, 1);
      check("t6_rsp_valid_1", bus.rsp_valid_1, 0);
      check("t6_rsp_valid_2", bus.rsp_valid_2, 0);
      tick();
      check("t6_rsp_valid_1_b", bus.rsp_valid_1, 0);
      check("t6_rsp_valid_2_b", bus.rsp_valid_2, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
